// File: rtl/ysyx_24100006_exe_mem_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_exe_mem_skid_if
// Brief    : Valid/ready bundle carrying one EXEU result (data + control).
//            Used on both the EXEU->boundary and boundary->MEMU sides.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24100006_exe_mem_skid_if;
  logic        valid;
  logic        ready;
  logic [31:0] alu_result;
  logic [31:0] wdata_gpr;
  logic [31:0] wdata_csr;
  logic        gpr_write;
  logic        csr_write;
  logic        irq;
  logic        is_break;
  logic [3:0]  gpr_write_addr;
  logic [11:0] csr_write_addr;
  logic [1:0]  gpr_write_rd;
  logic [1:0]  sram_read_write;  // bit0 = load, bit1 = store
  logic [2:0]  mem_mask;

  // Producer side: drives the bundle, observes ready
  modport master (
    output valid,
    output alu_result,
    output wdata_gpr,
    output wdata_csr,
    output gpr_write,
    output csr_write,
    output irq,
    output is_break,
    output gpr_write_addr,
    output csr_write_addr,
    output gpr_write_rd,
    output sram_read_write,
    output mem_mask,
    input  ready
  );

  // Consumer side: observes the bundle, drives ready
  modport slave (
    input  valid,
    input  alu_result,
    input  wdata_gpr,
    input  wdata_csr,
    input  gpr_write,
    input  csr_write,
    input  irq,
    input  is_break,
    input  gpr_write_addr,
    input  csr_write_addr,
    input  gpr_write_rd,
    input  sram_read_write,
    input  mem_mask,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100006_exe_mem_skid.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_exe_mem_skid
// Brief    : EXE->MEM pipeline boundary. Two-entry skid buffer (main + skid)
//            so that exe_in_ready comes straight from a flop while still
//            sustaining one bundle per cycle. Head entry also feeds the
//            hazard/forward unit.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100006_exe_mem_skid (
  input  wire logic                              clk,
  input  wire logic                              reset,      // async, active-low
  ysyx_24100006_exe_mem_skid_if.slave            exe_in,
  ysyx_24100006_exe_mem_skid_if.master           mem_out,
  output logic                                   mem_fw_valid,
  output logic [3:0]                             mem_fw_rd,
  output logic                                   mem_is_load,
  output logic [31:0]                            mem_fw_data
);

  // Packed payload width: 3x32 data + 4 flags + 4 rd + 12 csr + 2 + 2 + 3
  localparam int unsigned c_PAYLOAD_W = 123;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_in_ready;
  logic [c_PAYLOAD_W-1:0]   r_main_pl;
  logic [c_PAYLOAD_W-1:0]   r_skid_pl;
  logic [c_PAYLOAD_W-1:0]   w_in_pl;
  logic                     w_main_v;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_load_main_in;
  logic                     w_load_skid_in;
  logic                     w_load_main_skid;

  // Field order here defines the layout of both storage entries
  assign w_in_pl = {exe_in.alu_result,
                    exe_in.wdata_gpr,
                    exe_in.wdata_csr,
                    exe_in.gpr_write,
                    exe_in.csr_write,
                    exe_in.irq,
                    exe_in.is_break,
                    exe_in.gpr_write_addr,
                    exe_in.csr_write_addr,
                    exe_in.gpr_write_rd,
                    exe_in.sram_read_write,
                    exe_in.mem_mask};

  // Head entry is valid in ONE and TWO; skid only ever holds the younger bundle
  assign w_main_v   = (r_state != S_EMPTY);
  assign w_in_fire  = exe_in.valid & r_in_ready;
  assign w_out_fire = w_main_v & mem_out.ready;

  // Ready is a flop: the upstream never sees a combinational path from MEMU
  assign exe_in.ready = r_in_ready;

  // Occupancy state and registered ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != S_TWO);
    end
  end

  // Next-state and entry-load selection
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_skid_in   = 1'b0;
    w_load_main_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_next_state   = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves as the new bundle arrives: replace in place, no bubble
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_next_state   = S_TWO;
          w_load_skid_in = 1'b1;
        end else if (w_out_fire) begin
          w_next_state   = S_EMPTY;
        end
      end
      S_TWO: begin
        // Ready is low in TWO, so only the drain case exists
        if (w_out_fire) begin
          w_next_state     = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
      end
    endcase
  end

  // Head payload: written only on a load, otherwise keeps (possibly stale) data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_pl <= '0;
    end else if (w_load_main_in) begin
      r_main_pl <= w_in_pl;
    end else if (w_load_main_skid) begin
      r_main_pl <= r_skid_pl;
    end
  end

  // Skid payload: captures the bundle that arrived while the head was stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid_pl <= '0;
    end else if (w_load_skid_in) begin
      r_skid_pl <= w_in_pl;
    end
  end

  // Head entry drives the MEMU bundle
  assign mem_out.valid = w_main_v;
  assign {mem_out.alu_result,
          mem_out.wdata_gpr,
          mem_out.wdata_csr,
          mem_out.gpr_write,
          mem_out.csr_write,
          mem_out.irq,
          mem_out.is_break,
          mem_out.gpr_write_addr,
          mem_out.csr_write_addr,
          mem_out.gpr_write_rd,
          mem_out.sram_read_write,
          mem_out.mem_mask} = r_main_pl;

  // Forwarding view of the head; flags are gated so stale payload never forwards
  assign mem_fw_valid = w_main_v & mem_out.gpr_write;
  assign mem_fw_rd    = mem_out.gpr_write_addr;
  assign mem_is_load  = w_main_v & mem_out.sram_read_write[0];
  assign mem_fw_data  = mem_out.wdata_gpr;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_exe_mem_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100006_exe_mem_skid
// Brief    : Directed + randomized self-checking bench for the EXE->MEM skid
//            boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100006_exe_mem_skid;

  logic        clk;
  logic        reset;
  logic        mem_fw_valid;
  logic [3:0]  mem_fw_rd;
  logic        mem_is_load;
  logic [31:0] mem_fw_data;

  int total;
  int bad;

  ysyx_24100006_exe_mem_skid_if in_if ();
  ysyx_24100006_exe_mem_skid_if out_if ();

  ysyx_24100006_exe_mem_skid dut (
    .clk          (clk),
    .reset        (reset),
    .exe_in       (in_if),
    .mem_out      (out_if),
    .mem_fw_valid (mem_fw_valid),
    .mem_fw_rd    (mem_fw_rd),
    .mem_is_load  (mem_is_load),
    .mem_fw_data  (mem_fw_data)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // One comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu);
    in_if.valid           = v;
    in_if.alu_result      = alu;
    in_if.wdata_gpr       = ~alu;
    in_if.wdata_csr       = alu ^ 32'h5A5A_5A5A;
    in_if.gpr_write       = 1'b0;
    in_if.csr_write       = 1'b0;
    in_if.irq             = 1'b0;
    in_if.is_break        = 1'b0;
    in_if.gpr_write_addr  = 4'd0;
    in_if.csr_write_addr  = 12'd0;
    in_if.gpr_write_rd    = 2'd0;
    in_if.sram_read_write = 2'd0;
    in_if.mem_mask        = 3'd0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] seq;
    logic        in_v;
    logic        out_r;
    logic        inf;
    logic        outf;

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b0;
    drive(1'b0, 32'h0);
    out_if.ready = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_ready",    32'(in_if.ready), 32'd1);
    check("rst_valid",    32'(out_if.valid), 32'd0);
    check("rst_alu",      out_if.alu_result, 32'd0);
    check("rst_csr",      out_if.wdata_csr, 32'd0);
    check("rst_fw_valid", 32'(mem_fw_valid), 32'd0);
    check("rst_fw_data",  mem_fw_data, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_ready", 32'(in_if.ready), 32'd1);
      check("idle_valid", 32'(out_if.valid), 32'd0);
    end

    // ---------------- streaming ----------------
    out_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i));
      step();
      check("stream_valid", 32'(out_if.valid), 32'd1);
      check("stream_alu",   out_if.alu_result, 32'h100 + 32'(i));
      check("stream_ready", 32'(in_if.ready), 32'd1);
    end
    drive(1'b0, 32'h0);
    step();
    check("stream_drain_valid", 32'(out_if.valid), 32'd0);

    // ---------------- skid fill / drain ----------------
    out_if.ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    check("skid_a_alu",   out_if.alu_result, 32'hA);
    check("skid_a_ready", 32'(in_if.ready), 32'd1);
    drive(1'b1, 32'hB);
    step();
    check("skid_two_alu",   out_if.alu_result, 32'hA);
    check("skid_two_ready", 32'(in_if.ready), 32'd0);
    drive(1'b1, 32'hC);
    step();
    check("skid_hold_alu",   out_if.alu_result, 32'hA);
    check("skid_hold_wgpr",  out_if.wdata_gpr, ~32'hA);
    check("skid_hold_ready", 32'(in_if.ready), 32'd0);
    step();
    check("skid_hold2_alu", out_if.alu_result, 32'hA);
    out_if.ready = 1'b1;
    step();
    check("skid_b_alu",   out_if.alu_result, 32'hB);
    check("skid_b_ready", 32'(in_if.ready), 32'd1);
    step();
    check("skid_c_alu",   out_if.alu_result, 32'hC);
    check("skid_c_valid", 32'(out_if.valid), 32'd1);
    drive(1'b0, 32'h0);
    step();
    check("skid_drain_valid", 32'(out_if.valid), 32'd0);

    // ---------------- forwarding ----------------
    drive(1'b1, 32'h1234);
    in_if.sram_read_write = 2'b01;
    in_if.gpr_write       = 1'b1;
    in_if.gpr_write_addr  = 4'd5;
    in_if.wdata_gpr       = 32'hDEAD_0000;
    step();
    check("fw_is_load", 32'(mem_is_load), 32'd1);
    check("fw_valid",   32'(mem_fw_valid), 32'd1);
    check("fw_rd",      32'(mem_fw_rd), 32'd5);
    check("fw_data",    mem_fw_data, 32'hDEAD_0000);
    drive(1'b0, 32'h0);
    step();
    check("fw_drain_valid",   32'(mem_fw_valid), 32'd0);
    check("fw_drain_is_load", 32'(mem_is_load), 32'd0);

    // ---------------- async reset in TWO ----------------
    out_if.ready = 1'b0;
    drive(1'b1, 32'h777);
    step();
    drive(1'b1, 32'h888);
    step();
    check("two_ready_low", 32'(in_if.ready), 32'd0);
    drive(1'b0, 32'h0);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_if.valid), 32'd0);
    check("arst_ready", 32'(in_if.ready), 32'd1);
    check("arst_alu",   out_if.alu_result, 32'd0);
    step();
    reset = 1'b1;
    out_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_after_valid", 32'(out_if.valid), 32'd0);
    end

    // ---------------- random valid/ready with scoreboard ----------------
    seq = 32'h1000_0000;
    for (int c = 0; c < 10000; c++) begin
      in_v  = ($urandom_range(3) != 0);
      out_r = ($urandom_range(2) != 0);
      drive(in_v, seq);
      out_if.ready = out_r;
      check("rnd_valid", 32'(out_if.valid), 32'(q.size() != 0));
      check("rnd_ready", 32'(in_if.ready), 32'(q.size() != 2));
      inf  = in_v && in_if.ready;
      outf = out_if.valid && out_r;
      if (outf) begin
        if (q.size() != 0) begin
          check("rnd_order", out_if.alu_result, q[0]);
          void'(q.pop_front());
        end
      end
      if (inf) begin
        q.push_back(seq);
        seq = seq + 32'd1;
      end
      step();
    end
    drive(1'b0, 32'h0);
    out_if.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_if.valid && q.size() != 0) begin
        check("drain_order", out_if.alu_result, q[0]);
        void'(q.pop_front());
      end
      step();
    end
    check("drain_empty_q",     32'(q.size()), 32'd0);
    check("drain_empty_valid", 32'(out_if.valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
